// File: rtl/lsu_byte_sequencer.sv
// Byte-serial RV32I load/store sequencer: splits B/H/W requests into
// little-endian single-byte memory accesses and returns an extended result.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// ACCESS | one byte access per cycle; a rejected request spends one strobe-free cycle here
// DONE   | one-cycle response, then back to IDLE
module lsu_byte_sequencer #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        err_q;
  logic [1:0]  idx_q;
  logic [1:0]  rem_q;

  logic        accept;
  logic        req_legal;
  logic        req_misaligned;
  logic        req_err;
  logic [1:0]  rem_init;
  logic        last_beat;
  logic        access_act;
  logic [31:0] data_next;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b100:  r = {24'd0, d[7:0]};
      3'b101:  r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request decode; only consulted in IDLE, so req_* never reaches mem_*.
  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    rem_init       = 2'd0;
    if (req_we) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    case (req_funct3[1:0])
      2'b00:   rem_init = 2'd0;
      2'b01:   rem_init = 2'd1;
      default: rem_init = 2'd3;
    endcase
    if (!ALLOW_MISALIGNED) begin
      if (req_funct3[1:0] == 2'b01) req_misaligned = req_addr[0];
      if (req_funct3[1:0] == 2'b10) req_misaligned = (req_addr[1:0] != 2'b00);
    end
    req_err = !req_legal || req_misaligned;
  end

  assign accept     = (state_q == S_IDLE) && req_valid;
  assign last_beat  = (rem_q == 2'd0);
  assign access_act = (state_q == S_ACCESS) && !err_q;

  always_comb begin
    data_next = data_q;
    data_next[{idx_q, 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_ACCESS;
      S_ACCESS: if (last_beat) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      data_q   <= 32'd0;
      rdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= 2'd0;
      rem_q    <= 2'd0;
    end else if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      data_q   <= 32'd0;
      funct3_q <= req_funct3;
      we_q     <= req_we;
      err_q    <= req_err;
      idx_q    <= 2'd0;
      rem_q    <= req_err ? 2'd0 : rem_init;
    end else if (state_q == S_ACCESS) begin
      if (access_act && !we_q) data_q <= data_next;
      if (last_beat) begin
        rdata_q <= (we_q || err_q) ? 32'd0 : load_extend(funct3_q, data_next);
      end else begin
        idx_q <= idx_q + 2'd1;
        rem_q <= rem_q - 2'd1;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;

  assign mem_re    = access_act && !we_q;
  assign mem_we    = access_act && we_q;
  assign mem_addr  = access_act ? (addr_q + {30'd0, idx_q}) : 32'd0;
  assign mem_wdata = mem_we ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Self-checking bench: directed vector table, reset-abort sequence and
// randomized traffic against a byte-array reference model.
module tb_lsu_byte_sequencer;

  logic        clk;
  logic        reset;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_valid, req_ready, resp_valid, resp_err, mem_re, mem_we;
  logic [31:0] resp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        req_valid2, req_ready2, resp_valid2, resp_err2, mem_re2, mem_we2;
  logic [31:0] resp_rdata2, mem_addr2;
  logic [7:0]  mem_wdata2, mem_rdata2;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap_cnt = 0;

  logic [7:0]  mem_arr [256] = '{default: 8'h00};
  logic [7:0]  model_mem [256];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];
  logic [31:0] rd_a [$];

  lsu_byte_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_byte_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_we(mem_we2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata  = mem_arr[mem_addr[7:0]];
  assign mem_rdata2 = mem_arr[mem_addr2[7:0]];

  // Memory is 256 bytes aliased on addr[7:0]; both DUTs share it.
  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
    end
    if (mem_we2) begin
      mem_arr[mem_addr2[7:0]] <= mem_wdata2;
      wr_a.push_back(mem_addr2);
      wr_d.push_back(mem_wdata2);
    end
    if (mem_re)  rd_a.push_back(mem_addr);
    if (mem_re2) rd_a.push_back(mem_addr2);
    if ((mem_re && mem_we) || (mem_re2 && mem_we2)) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference: sizes, legality and extension from the ISA rules on a byte array.
  task automatic model(input bit allow, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err, output int lat,
                       output int nwr, output int nrd);
    int n;
    logic [31:0] a, val;
    n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    if (!allow && !err && (addr % n) != 0) err = 1'b1;
    rd = 32'd0; nwr = 0; nrd = 0;
    if (err) begin
      lat = 2;
    end else begin
      lat = n + 1;
      val = 32'd0;
      for (int i = 0; i < n; i++) begin
        a = addr + i;
        if (we) model_mem[a[7:0]] = 8'((wd >> (8 * i)) & 32'hFF);
        else    val = val + ({24'd0, model_mem[a[7:0]]} << (8 * i));
      end
      if (we) begin
        nwr = n;
      end else begin
        nrd = n;
        rd  = val;
        if (f3 == 3'b000) begin
          rd = {24'd0, val[7:0]};
          if (val[7]) rd = rd - 32'd256;
        end else if (f3 == 3'b001) begin
          rd = {16'd0, val[15:0]};
          if (val[15]) rd = rd - 32'h10000;
        end else if (f3 == 3'b100) begin
          rd = {24'd0, val[7:0]};
        end else if (f3 == 3'b101) begin
          rd = {16'd0, val[15:0]};
        end
      end
    end
  endtask

  task automatic run_req(input bit use2, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output bit err, output int lat);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (use2) req_valid2 = 1'b1;
    else      req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_valid2 = 1'b0;
    req_addr = 32'h5A5A_5A5A; req_wdata = 32'h0; req_funct3 = 3'b111;
    lat = 1;
    while (!(use2 ? resp_valid2 : resp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd  = use2 ? resp_rdata2 : resp_rdata;
    err = use2 ? resp_err2 : resp_err;
    @(negedge clk);
    chk("resp_pulse_one_cycle", {31'd0, use2 ? resp_valid2 : resp_valid}, 32'd0);
    chk("rdata_hold", use2 ? resp_rdata2 : resp_rdata, rd);
  endtask

  typedef struct {
    bit          use2;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    int          lat;
    int          nwr;
    int          nrd;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [31:0] rd, m_rd, a;
    bit err, m_err, use2, we;
    int lat, m_lat, m_nwr, m_nrd, ws, rs, pulses;
    logic [2:0] f3;

    vecs.push_back('{0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0, 5, 4, 0});
    vecs.push_back('{0, 0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 0, 2, 0, 1});
    vecs.push_back('{0, 0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_00DE, 0, 2, 0, 1});
    vecs.push_back('{0, 0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 0, 3, 0, 2});
    vecs.push_back('{0, 0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 0, 3, 0, 2});
    vecs.push_back('{0, 0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 5, 0, 4});
    vecs.push_back('{0, 1, 3'b001, 32'h0000_0021, 32'h0000_A55A, 32'h0000_0000, 0, 3, 2, 0});
    vecs.push_back('{0, 0, 3'b101, 32'h0000_0021, 32'h0,         32'h0000_A55A, 0, 3, 0, 2});
    vecs.push_back('{1, 1, 3'b001, 32'h0000_0021, 32'h0000_A55A, 32'h0000_0000, 1, 2, 0, 0});
    vecs.push_back('{0, 0, 3'b011, 32'h0000_0010, 32'h0,         32'h0000_0000, 1, 2, 0, 0});
    vecs.push_back('{1, 0, 3'b011, 32'h0000_0033, 32'h0,         32'h0000_0000, 1, 2, 0, 0});
    vecs.push_back('{0, 1, 3'b100, 32'h0000_0010, 32'h0000_00FF, 32'h0000_0000, 1, 2, 0, 0});
    vecs.push_back('{1, 0, 3'b010, 32'h0000_0022, 32'h0,         32'h0000_0000, 1, 2, 0, 0});
    vecs.push_back('{1, 0, 3'b001, 32'h0000_0020, 32'h0,         32'h0000_5A00, 0, 3, 0, 2});
    vecs.push_back('{1, 0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 0, 2, 0, 1});
    vecs.push_back('{0, 1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0000_0000, 0, 5, 4, 0});
    vecs.push_back('{0, 0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'h1122_3344, 0, 5, 0, 4});
    vecs.push_back('{1, 1, 3'b010, 32'h0000_0030, 32'hCAFE_BABE, 32'h0000_0000, 0, 5, 4, 0});
    vecs.push_back('{0, 0, 3'b000, 32'h0000_0033, 32'h0,         32'hFFFF_FFCA, 0, 2, 0, 1});

    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      ws = wr_a.size(); rs = rd_a.size();
      model(!vecs[i].use2, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd,
            m_rd, m_err, m_lat, m_nwr, m_nrd);
      run_req(vecs[i].use2, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_nwrites", i), wr_a.size() - ws, vecs[i].nwr);
      chk($sformatf("vec%0d_nreads", i), rd_a.size() - rs, vecs[i].nrd);
      if (wr_a.size() - ws == vecs[i].nwr) begin
        for (int k = 0; k < vecs[i].nwr; k++) begin
          chk($sformatf("vec%0d_wr_addr%0d", i, k), wr_a[ws + k], vecs[i].addr + k);
          chk($sformatf("vec%0d_wr_byte%0d", i, k), {24'd0, wr_d[ws + k]},
              (vecs[i].wd >> (8 * k)) & 32'hFF);
        end
      end
      if (rd_a.size() - rs == vecs[i].nrd) begin
        for (int k = 0; k < vecs[i].nrd; k++)
          chk($sformatf("vec%0d_rd_addr%0d", i, k), rd_a[rs + k], vecs[i].addr + k);
      end
    end

    // Abort a word store after its first byte has been committed.
    ws = wr_a.size();
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_we_active", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_we_dropped", {30'd0, mem_re, mem_we}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("abort_partial_writes", wr_a.size() - ws, 32'd1);
    if (wr_a.size() - ws == 1) chk("abort_first_byte", {24'd0, wr_d[ws]}, 32'h0D);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("abort_no_late_resp", pulses, 32'd0);
    model(1'b1, 1'b1, 3'b010, 32'h40, 32'h1357_9BDF, m_rd, m_err, m_lat, m_nwr, m_nrd);
    run_req(1'b0, 1'b1, 3'b010, 32'h40, 32'h1357_9BDF, rd, err, lat);
    model(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, m_rd, m_err, m_lat, m_nwr, m_nrd);
    run_req(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, rd, err, lat);
    chk("after_abort_lw", rd, 32'h1357_9BDF);
    chk("after_abort_lw_lat", lat, 32'd5);

    for (int t = 0; t < 120; t++) begin
      use2 = ($urandom_range(0, 3) == 0);
      we   = $urandom_range(0, 1) == 1;
      f3   = 3'($urandom_range(0, 7));
      a    = {($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'h000000, 8'($urandom)};
      req_wdata = $urandom;
      ws = wr_a.size(); rs = rd_a.size();
      model(!use2, we, f3, a, req_wdata, m_rd, m_err, m_lat, m_nwr, m_nrd);
      run_req(use2, we, f3, a, req_wdata, rd, err, lat);
      chk($sformatf("rand%0d_rdata", t), rd, m_rd);
      chk($sformatf("rand%0d_err", t), {31'd0, err}, {31'd0, m_err});
      chk($sformatf("rand%0d_latency", t), lat, m_lat);
      chk($sformatf("rand%0d_nwrites", t), wr_a.size() - ws, m_nwr);
      chk($sformatf("rand%0d_nreads", t), rd_a.size() - rs, m_nrd);
    end

    chk("re_we_overlap", overlap_cnt, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
